awg_cmd_parser: RTL and testbench



---
 rtl/awg_cfg_pkg.sv | 53 +++++
 rtl/awg_cmd_parser_dec_accum.sv | 34 +++
 rtl/awg_cmd_parser.sv | 113 +++++++++++
 tb/tb_awg_cmd_parser.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/awg_cfg_pkg.sv
// awg_cfg_pkg: shared FSM states, ASCII codes, field limits and reset defaults for the AWG config path.
package awg_cfg_pkg;
    typedef enum logic [1:0] {IDLE, OPCODE, DIGITS, DISCARD} state_t;
    typedef enum logic [1:0] {OP_W, OP_F, OP_A, OP_P} op_t;

    localparam logic [7:0] ASC_W  = 8'h57;
    localparam logic [7:0] ASC_F  = 8'h46;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_SP = 8'h20;

    localparam int ACC_W      = 17;
    localparam int MAX_DIGITS = 5;
    localparam int WAVE_W     = 5;
    localparam int FREQ_W     = 12;
    localparam int AMP_W      = 3;
    localparam int PHASE_W    = 8;

    localparam logic [ACC_W-1:0] FREQ_MIN  = 17'd1;
    localparam logic [ACC_W-1:0] FREQ_MAX  = 17'd4095;
    localparam logic [ACC_W-1:0] AMP_MAX   = 17'd7;
    localparam logic [ACC_W-1:0] PHASE_MAX = 17'd255;

    localparam logic [WAVE_W-1:0]  WAVE_RST  = 5'd0;
    localparam logic [FREQ_W-1:0]  FREQ_RST  = 12'd1;
    localparam logic [AMP_W-1:0]   AMP_RST   = 3'd2;
    localparam logic [PHASE_W-1:0] PHASE_RST = 8'd50;

    // Clearing bit 5 folds lowercase opcode letters onto uppercase.
    function automatic logic is_op(input logic [7:0] b);
        logic [7:0] u;
        u = b & 8'hDF;
        return u == ASC_W || u == ASC_F || u == ASC_A || u == ASC_P;
    endfunction

    function automatic op_t op_of(input logic [7:0] b);
        logic [7:0] u;
        u = b & 8'hDF;
        return u == ASC_W ? OP_W : u == ASC_F ? OP_F : u == ASC_A ? OP_A : OP_P;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return b >= ASC_0 && b <= ASC_9;
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return b == ASC_CR || b == ASC_LF;
    endfunction
endpackage

// File: rtl/awg_cmd_parser_dec_accum.sv
// dec_accum: decimal digit accumulator (acc*10+digit) with digit count and a full flag
// that marks the next digit as one too many.
module dec_accum
    import awg_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc,
    output logic             full
);
    logic [2:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (clr) begin
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= ACC_W'(digit);
            count <= 3'd1;
        end else if (push) begin
            acc   <= acc * ACC_W'(10) + ACC_W'(digit);
            count <= count + 3'd1;
        end
    end

    assign full = count == 3'(MAX_DIGITS);
endmodule

// File: rtl/awg_cmd_parser.sv
// awg_cmd_parser: decodes ASCII opcode+decimal commands into range-checked AWG
// configuration registers with one-cycle update and error strobes.
module awg_cmd_parser
    import awg_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int WAVE_MAX       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [WAVE_W-1:0]  wave_sel,
    output logic [FREQ_W-1:0]  freq_word,
    output logic [AMP_W-1:0]   amp_sel,
    output logic [PHASE_W-1:0] phase_off,
    output logic               cfg_update,
    output logic               cmd_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state, next;
    op_t                 op;
    logic [TW-1:0]       tcnt;
    logic [ACC_W-1:0]    acc;
    logic                full, timeout, is_o, is_d, is_t, is_s;
    logic                acc_clr, acc_load, acc_push, term, in_range, commit, err_d;
    logic [WAVE_W-1:0]   wave_n;
    logic [FREQ_W-1:0]   freq_n;
    logic [AMP_W-1:0]    amp_n;
    logic [PHASE_W-1:0]  phase_n;

    dec_accum u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .load  (acc_load),
        .push  (acc_push),
        .digit (rx_data[3:0]),
        .acc   (acc),
        .full  (full)
    );

    assign is_o = is_op(rx_data);
    assign is_d = is_digit(rx_data);
    assign is_t = is_term(rx_data);
    assign is_s = rx_data == ASC_SP;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = state != IDLE && !rx_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        if (timeout)
            next = IDLE;
        else if (rx_valid)
            case (state)
                IDLE:    next = is_o ? OPCODE : (is_t || is_s) ? IDLE : DISCARD;
                OPCODE:  next = is_d ? DIGITS : DISCARD;
                DIGITS:  next = is_d ? (full ? DISCARD : DIGITS) : is_t ? IDLE : DISCARD;
                default: next = is_t ? IDLE : DISCARD;
            endcase
    end

    always_comb begin
        acc_clr  = rx_valid && state == IDLE && is_o;
        acc_load = rx_valid && state == OPCODE && is_d;
        acc_push = rx_valid && state == DIGITS && is_d && !full;
        term     = rx_valid && state == DIGITS && is_t;
        in_range = op == OP_W ? acc <= ACC_W'(WAVE_MAX) :
                   op == OP_F ? acc >= FREQ_MIN && acc <= FREQ_MAX :
                   op == OP_A ? acc <= AMP_MAX : acc <= PHASE_MAX;
        commit   = term && in_range;
        err_d    = (timeout && state != DISCARD) || (next == DISCARD && state != DISCARD) ||
                   (term && !in_range);
        wave_n   = commit && op == OP_W ? acc[WAVE_W-1:0]  : wave_sel;
        freq_n   = commit && op == OP_F ? acc[FREQ_W-1:0]  : freq_word;
        amp_n    = commit && op == OP_A ? acc[AMP_W-1:0]   : amp_sel;
        phase_n  = commit && op == OP_P ? acc[PHASE_W-1:0] : phase_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            op   <= OP_W;
        end else begin
            tcnt <= (state == IDLE || rx_valid || timeout) ? '0 : tcnt + TW'(1);
            if (acc_clr) op <= op_of(rx_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_sel   <= WAVE_RST;
            freq_word  <= FREQ_RST;
            amp_sel    <= AMP_RST;
            phase_off  <= PHASE_RST;
            cfg_update <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            wave_sel   <= wave_n;
            freq_word  <= freq_n;
            amp_sel    <= amp_n;
            phase_off  <= phase_n;
            cfg_update <= {wave_n, freq_n, amp_n, phase_n} != {wave_sel, freq_word, amp_sel, phase_off};
            cmd_err    <= err_d;
        end
    end
endmodule

// File: tb/tb_awg_cmd_parser.sv
// tb_awg_cmd_parser: directed command strings with hand-computed register, strobe-count
// and timeout-latency expectations.
module tb_awg_cmd_parser;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] wave_sel;
    logic [11:0] freq_word;
    logic [2:0] amp_sel;
    logic [7:0] phase_off;
    logic       cfg_update;
    logic       cmd_err;

    int checks = 0;
    int failures = 0;
    int upd_n = 0;
    int err_n = 0;
    int u0, e0;

    awg_cmd_parser #(.TIMEOUT_CYCLES(100), .WAVE_MAX(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wave_sel   (wave_sel),
        .freq_word  (freq_word),
        .amp_sel    (amp_sel),
        .phase_off  (phase_off),
        .cfg_update (cfg_update),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) upd_n++;
        if (cmd_err === 1'b1) err_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives bytes back-to-back; returns on the negedge one cycle after the last byte.
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hFF;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input string tag, input string s, input int du, input int de);
        u0 = upd_n;
        e0 = err_n;
        send(s);
        settle();
        chk({tag, "_upd"}, upd_n - u0, du);
        chk({tag, "_err"}, err_n - e0, de);
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wave", wave_sel, 0);
        chk("rst_freq", freq_word, 1);
        chk("rst_amp", amp_sel, 2);
        chk("rst_phase", phase_off, 50);
        chk("rst_upd", cfg_update, 0);
        chk("rst_err", cmd_err, 0);
        rst = 1'b0;
        settle();

        u0 = upd_n;
        e0 = err_n;
        send("F1000\015");
        chk("f1000_lat_freq", freq_word, 1000);
        chk("f1000_lat_upd", cfg_update, 1);
        settle();
        chk("f1000_upd", upd_n - u0, 1);
        chk("f1000_err", err_n - e0, 0);

        cmd("f0042", "f0042\n", 1, 0);
        chk("f0042_freq", freq_word, 42);
        cmd("a9", "A9\n", 0, 1);
        chk("a9_amp", amp_sel, 2);
        cmd("f0", "F0\n", 0, 1);
        cmd("f4096", "F4096\n", 0, 1);
        cmd("f99999", "F99999\n", 0, 1);
        cmd("f123456", "F123456\n", 0, 1);
        chk("bad_freq", freq_word, 42);
        cmd("f4095", "F4095\n", 1, 0);
        chk("f4095_freq", freq_word, 4095);
        cmd("p50", "P50\015\n", 0, 0);
        chk("p50_phase", phase_off, 50);
        cmd("w11", "W11\n", 0, 1);
        chk("w11_wave", wave_sel, 0);
        cmd("w10", "W10\n", 1, 0);
        chk("w10_wave", wave_sel, 10);
        cmd("a7", "a7\n", 1, 0);
        chk("a7_amp", amp_sel, 7);
        cmd("p255", "p255\n", 1, 0);
        chk("p255_phase", phase_off, 255);
        cmd("a5x", "A5x\n", 0, 1);
        chk("a5x_amp", amp_sel, 7);
        cmd("badop", "X12\n", 0, 1);
        cmd("space", " \n", 0, 0);

        e0 = err_n;
        send("F12");
        repeat (99) @(negedge clk);
        chk("to_early_err", cmd_err, 0);
        chk("to_early_cnt", err_n - e0, 0);
        @(negedge clk);
        chk("to_err", cmd_err, 1);
        settle();
        chk("to_cnt", err_n - e0, 1);
        cmd("to_3", "3\n", 0, 1);
        chk("to_freq", freq_word, 4095);

        e0 = err_n;
        send("P2");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_wave", wave_sel, 0);
        chk("mid_rst_freq", freq_word, 1);
        chk("mid_rst_amp", amp_sel, 2);
        chk("mid_rst_phase", phase_off, 50);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_err", err_n - e0, 0);
        cmd("post_rst", "00\n", 0, 1);
        chk("post_rst_phase", phase_off, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
